wavetable_ram: RTL and testbench
================================

Name: wavetable_ram

Overview:
- Parametrised single-clock wavetable memory for the signal generator, successor to the basic single-port RAM.
- Separate synchronous write port for table loading; read side is driven by an internal fixed-point phase accumulator.
- Plays the stored table from address 0 to a programmable end address, in loop or one-shot mode, at a fractional step rate.
- Feeds samples to the generator output path.

Parameters:
- DATA_WIDTH, 8, sample/word width.
- ADDR_WIDTH, 8, table address width; depth = 2**ADDR_WIDTH.
- FRAC_WIDTH, 8, fractional bits of phase and step.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- start  in  1  begin/retrigger playback (single-cycle pulse).
- stop  in  1  abort playback.
- mode  in  1  0 = loop, 1 = one-shot; latched on start.
- step  in  ADDR_WIDTH+FRAC_WIDTH  phase increment, unsigned fixed point; latched on start.
- end_addr  in  ADDR_WIDTH  last table address played; latched on start.
- busy  out  1  high while in PLAY.
- sample_out  out  DATA_WIDTH  registered table sample.
- sample_valid  out  1  sample_out holds a new sample this cycle.
- done  out  1  one-cycle pulse with the final one-shot sample.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, phase 0, latched config 0; busy, sample_out, sample_valid, done, err all 0. Memory contents are not cleared.
- Write path: mem[wr_addr] <= wr_data on the clock edge when wr_en=1. Writes are legal in any state.
- Read/write collision on the same address in the same cycle is read-first: sample_out gets the old word.
- Phase: register of ADDR_WIDTH+FRAC_WIDTH bits; read address = phase[top ADDR_WIDTH bits]; span = end_addr+1.
- States: IDLE and PLAY.
- IDLE:
  - start=1 and stop=0 and step integer part <= end_addr: latch mode, step and end_addr; phase <= 0; go to PLAY.
  - step integer part > end_addr: start is rejected; err pulses the following cycle; stay IDLE.
- PLAY, every cycle:
  - Read mem[addr]; result registered into sample_out with sample_valid=1 on the next edge (1-cycle read latency).
  - Next phase is phase+step, computed one bit wider.
  - If its integer part exceeds end_addr:
    - Loop mode: phase <= (phase+step) - (span << FRAC_WIDTH). Fraction is preserved, single subtraction, always in range because of the start check.
    - One-shot mode: go to IDLE. The sample read this cycle is the last; done=1 on the same cycle its sample_valid=1.
- step=0 in PLAY: holds the same address, producing a valid sample every cycle until stop.
- Priority: stop over start; stop in PLAY returns to IDLE on the next edge.
  - No further sample_valid after that edge, except the sample already in flight from the stop cycle's read, which is suppressed (sample_valid=0).
  - done is not pulsed on stop.
- start in PLAY (stop=0): retrigger. Re-latch config, phase <= 0, stay PLAY, no done. Rejected retrigger: err pulse, playback continues unchanged.
- busy=1 exactly while state=PLAY.
- Latency: start sampled at edge 0 -> busy=1 after edge 0 -> first sample_valid after edge 1 holds mem[0].
- sample_out holds its last value when sample_valid=0.

Test Plan:
- Load mem[a]=3*a for a=0..15, then loop with end_addr=3, step=0x100 -> sample_out 0,3,6,9,0,3,6,9 on consecutive valid cycles; busy stays 1; done never asserts.
- One-shot, end_addr=7, step=0x180 -> addresses 0,1,3,4,6,7 -> samples 0,3,9,12,18,21; done=1 with sample 21; next cycle busy=0, sample_valid=0.
- Loop, end_addr=3, step=0x180 -> addresses 0,1,3,0,2,3,1 -> samples 0,3,9,0,6,9,3 (fractional wrap preserved).
- Start with step=0x500, end_addr=3 -> err pulses once, busy stays 0. Then stop and start in the same cycle during PLAY -> IDLE next cycle, no done.
- During loop play, write mem[1]=0xAA in the cycle address 1 is read -> old value 3 is output; the next pass outputs 0xAA.
- Drive rst low mid-playback, asynchronously between edges -> busy, sample_valid, sample_out go to 0 immediately. After release, a new start with end_addr=3, step=0x100 plays 0,3,6,9 (memory retained).

Source files
------------

// File: rtl/wavetable_ram_if.sv
// Wavetable RAM bus interface.
// Groups the table write port, the playback control inputs and the sample output
// stream. The master modport belongs to the block driving the controls. The slave
// modport belongs to wavetable_ram.
//   wr_en/wr_addr/wr_data : table load port
//   start/stop/mode/step/end_addr : playback control
//   busy/sample_out/sample_valid/done/err : playback status and sample stream
interface wavetable_ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FRAC_WIDTH = 8
);
    logic                             wr_en;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [DATA_WIDTH-1:0]            wr_data;
    logic                             start;
    logic                             stop;
    logic                             mode;
    logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0]            end_addr;
    logic                             busy;
    logic [DATA_WIDTH-1:0]            sample_out;
    logic                             sample_valid;
    logic                             done;
    logic                             err;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, mode, step, end_addr,
        input  busy, sample_out, sample_valid, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, mode, step, end_addr,
        output busy, sample_out, sample_valid, done, err
    );
endinterface

// File: rtl/wavetable_ram.sv
// Wavetable memory with a phase-accumulator read side.
// The table is loaded through a synchronous write port. Playback runs from address
// 0 to a programmable end address. The read address advances by a fixed-point step
// every cycle. Playback either loops (the fraction is preserved across the wrap) or
// stops after one pass. Samples appear one cycle after their read.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : wavetable_ram_if slave (write port, playback control, sample stream)
module wavetable_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FRAC_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    wavetable_ram_if.slave bus
);
    localparam int unsigned PW    = ADDR_WIDTH + FRAC_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic                  mode_q, mode_d;
    logic [PW-1:0]         step_q, step_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] sample_q;
    logic                  load_sample;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [PW:0]           sum;
    logic [ADDR_WIDTH:0]   sum_int;
    logic [ADDR_WIDTH-1:0] span_lo;
    logic [PW-1:0]         wrapped;
    logic                  start_req;
    logic                  start_ok;

    assign rd_addr   = phase_q[PW-1 -: ADDR_WIDTH];
    assign start_req = bus.start && !bus.stop;
    assign start_ok  = (bus.step[PW-1 -: ADDR_WIDTH] <= bus.end_addr);

    // The next phase is one bit wider, so an overflow past the table top is still
    // visible to the end-address compare.
    assign sum     = {1'b0, phase_q} + {1'b0, step_q};
    assign sum_int = sum[PW:FRAC_WIDTH];
    // The subtraction works modulo 2**PW. The start check guarantees that the
    // true result is in range. So span = end+1 may wrap to 0 when end is all
    // ones, and that gives the correct answer.
    assign span_lo = end_q + 1'b1;
    assign wrapped = sum[PW-1:0] - {span_lo, {FRAC_WIDTH{1'b0}}};

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        step_d      = step_q;
        end_d       = end_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_sample = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    if (start_ok) begin
                        mode_d  = bus.mode;
                        step_d  = bus.step;
                        end_d   = bus.end_addr;
                        phase_d = '0;
                        state_d = PLAY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    // The read issued this cycle is dropped, and no done pulse is sent.
                    state_d = IDLE;
                end else begin
                    valid_d     = 1'b1;
                    load_sample = 1'b1;
                    if (bus.start && start_ok) begin
                        mode_d  = bus.mode;
                        step_d  = bus.step;
                        end_d   = bus.end_addr;
                        phase_d = '0;
                    end else begin
                        if (bus.start) begin
                            err_d = 1'b1;
                        end
                        if (sum_int > {1'b0, end_q}) begin
                            if (mode_q) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                phase_d = wrapped;
                            end
                        end else begin
                            phase_d = sum[PW-1:0];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            mode_q  <= 1'b0;
            step_q  <= '0;
            end_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The read and the write share an edge. The non-blocking write means a
    // same-address read returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= '0;
        end else if (load_sample) begin
            sample_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.busy         = (state_q == PLAY);
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_wavetable_ram.sv
module tb_wavetable_ram;
    logic clk;
    logic rst;
    int   tests_run;
    int   failed;

    wavetable_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .FRAC_WIDTH(8)) bus ();

    wavetable_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .FRAC_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic begin_play(input logic m, input logic [15:0] s, input logic [7:0] e);
        bus.mode = m; bus.step = s; bus.end_addr = e; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic stop_play();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", bus.sample_valid); end
        tests_run++; if (bus.sample_out !== 8'd0) begin failed++; $display("FAIL reset_sample: got %0d expected 0", bus.sample_out); end
        tests_run++; if (bus.done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests_run++; if (bus.err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_loop();
        logic [7:0] exp_s [8] = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd0, 8'd3, 8'd6, 8'd9};
        begin_play(1'b0, 16'h0100, 8'd3);
        tests_run++; if (bus.busy !== 1'b1) begin failed++; $display("FAIL loop_busy_start: got %b expected 1", bus.busy); end
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL loop_latency: got %b expected 0", bus.sample_valid); end
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++; if (bus.sample_valid !== 1'b1) begin failed++; $display("FAIL loop_valid[%0d]: got %b expected 1", i, bus.sample_valid); end
            tests_run++; if (bus.sample_out !== exp_s[i]) begin failed++; $display("FAIL loop_sample[%0d]: got %0d expected %0d", i, bus.sample_out, exp_s[i]); end
            tests_run++; if (bus.busy !== 1'b1) begin failed++; $display("FAIL loop_busy[%0d]: got %b expected 1", i, bus.busy); end
            tests_run++; if (bus.done !== 1'b0) begin failed++; $display("FAIL loop_done[%0d]: got %b expected 0", i, bus.done); end
        end
        stop_play();
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL loop_stop_busy: got %b expected 0", bus.busy); end
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL loop_stop_valid: got %b expected 0", bus.sample_valid); end
        tests_run++; if (bus.done !== 1'b0) begin failed++; $display("FAIL loop_stop_done: got %b expected 0", bus.done); end
        tests_run++; if (bus.sample_out !== 8'd9) begin failed++; $display("FAIL loop_stop_hold: got %0d expected 9", bus.sample_out); end
        tick();
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL loop_after_stop_valid: got %b expected 0", bus.sample_valid); end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_s [6] = '{8'd0, 8'd3, 8'd9, 8'd12, 8'd18, 8'd21};
        begin_play(1'b1, 16'h0180, 8'd7);
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++; if (bus.sample_valid !== 1'b1) begin failed++; $display("FAIL os_valid[%0d]: got %b expected 1", i, bus.sample_valid); end
            tests_run++; if (bus.sample_out !== exp_s[i]) begin failed++; $display("FAIL os_sample[%0d]: got %0d expected %0d", i, bus.sample_out, exp_s[i]); end
            tests_run++; if (bus.done !== (i == 5)) begin failed++; $display("FAIL os_done[%0d]: got %b expected %b", i, bus.done, (i == 5)); end
            tests_run++; if (bus.busy !== (i < 5)) begin failed++; $display("FAIL os_busy[%0d]: got %b expected %b", i, bus.busy, (i < 5)); end
        end
        tick();
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL os_end_busy: got %b expected 0", bus.busy); end
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL os_end_valid: got %b expected 0", bus.sample_valid); end
        tests_run++; if (bus.done !== 1'b0) begin failed++; $display("FAIL os_end_done: got %b expected 0", bus.done); end
        tests_run++; if (bus.sample_out !== 8'd21) begin failed++; $display("FAIL os_end_hold: got %0d expected 21", bus.sample_out); end
    endtask

    task automatic test_frac_loop();
        logic [7:0] exp_s [7] = '{8'd0, 8'd3, 8'd9, 8'd0, 8'd6, 8'd9, 8'd3};
        begin_play(1'b0, 16'h0180, 8'd3);
        for (int i = 0; i < 7; i++) begin
            tick();
            tests_run++; if (bus.sample_valid !== 1'b1) begin failed++; $display("FAIL frac_valid[%0d]: got %b expected 1", i, bus.sample_valid); end
            tests_run++; if (bus.sample_out !== exp_s[i]) begin failed++; $display("FAIL frac_sample[%0d]: got %0d expected %0d", i, bus.sample_out, exp_s[i]); end
        end
        stop_play();
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL frac_stop_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_err_and_stop();
        begin_play(1'b0, 16'h0500, 8'd3);
        tests_run++; if (bus.err !== 1'b1) begin failed++; $display("FAIL err_pulse: got %b expected 1", bus.err); end
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL err_busy: got %b expected 0", bus.busy); end
        tick();
        tests_run++; if (bus.err !== 1'b0) begin failed++; $display("FAIL err_once: got %b expected 0", bus.err); end
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL err_busy2: got %b expected 0", bus.busy); end
        begin_play(1'b0, 16'h0100, 8'd3);
        tick();
        tests_run++; if (bus.sample_out !== 8'd0) begin failed++; $display("FAIL ss_pre_sample: got %0d expected 0", bus.sample_out); end
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL ss_busy: got %b expected 0", bus.busy); end
        tests_run++; if (bus.done !== 1'b0) begin failed++; $display("FAIL ss_done: got %b expected 0", bus.done); end
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL ss_valid: got %b expected 0", bus.sample_valid); end
        tick();
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL ss_busy2: got %b expected 0", bus.busy); end
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL ss_valid2: got %b expected 0", bus.sample_valid); end
    endtask

    task automatic test_collision();
        logic [7:0] exp_s [4] = '{8'd6, 8'd9, 8'd0, 8'hAA};
        begin_play(1'b0, 16'h0100, 8'd3);
        tick();
        tests_run++; if (bus.sample_out !== 8'd0) begin failed++; $display("FAIL col_first: got %0d expected 0", bus.sample_out); end
        // address 1 is being read in this cycle
        bus.wr_en = 1'b1; bus.wr_addr = 8'd1; bus.wr_data = 8'hAA;
        tick();
        bus.wr_en = 1'b0;
        tests_run++; if (bus.sample_out !== 8'd3) begin failed++; $display("FAIL col_read_first: got %0d expected 3", bus.sample_out); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (bus.sample_out !== exp_s[i]) begin failed++; $display("FAIL col_pass[%0d]: got %0d expected %0d", i, bus.sample_out, exp_s[i]); end
        end
        stop_play();
        write_word(8'd1, 8'd3);
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_s [4] = '{8'd0, 8'd3, 8'd6, 8'd9};
        begin_play(1'b0, 16'h0100, 8'd3);
        tick(); tick(); tick();
        tests_run++; if (bus.sample_out !== 8'd6) begin failed++; $display("FAIL ar_pre: got %0d expected 6", bus.sample_out); end
        #2 rst = 1'b0;
        #1;
        tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL ar_busy: got %b expected 0", bus.busy); end
        tests_run++; if (bus.sample_valid !== 1'b0) begin failed++; $display("FAIL ar_valid: got %b expected 0", bus.sample_valid); end
        tests_run++; if (bus.sample_out !== 8'd0) begin failed++; $display("FAIL ar_sample: got %0d expected 0", bus.sample_out); end
        tick();
        @(negedge clk) rst = 1'b1;
        tick();
        begin_play(1'b0, 16'h0100, 8'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (bus.sample_valid !== 1'b1) begin failed++; $display("FAIL ar_play_valid[%0d]: got %b expected 1", i, bus.sample_valid); end
            tests_run++; if (bus.sample_out !== exp_s[i]) begin failed++; $display("FAIL ar_play_sample[%0d]: got %0d expected %0d", i, bus.sample_out, exp_s[i]); end
        end
        stop_play();
    endtask

    initial begin
        tests_run = 0; failed = 0;
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.step = '0; bus.end_addr = '0;
        tick(); tick();
        @(negedge clk) rst = 1'b1;
        tick();
        test_reset();
        for (int a = 0; a < 16; a++) begin
            write_word(8'(a), 8'(3 * a));
        end
        test_loop();
        test_oneshot();
        test_frac_loop();
        test_err_and_stop();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
